com_cdc_hs_tx: RTL and testbench
================================

Name: com_cdc_hs_tx

Overview:
- Source-side (transmitter) end of a 4-phase req/ack handshake that carries a DATA_WIDTH word from the i_clk domain to a foreign clock domain.
- Captures the word, holds it stable on o_xfer_data, and raises o_xfer_req.
- Synchronizes the returning asynchronous i_xfer_ack into i_clk through a NUM_STAGES flop chain, then completes the 4-phase sequence.
- Sits in front of every multi-bit control/config path crossing out of the main firmware clock.

Parameters:
- DATA_WIDTH, 16: width of the transferred word.
- NUM_STAGES, 2: depth of the ack synchronizer. Minimum 2.
- TIMEOUT_CYCLES, 1024: max i_clk cycles spent in any one wait state. 0 disables the timeout.
- CNT_WIDTH, 16: width of the completed-transfer counter.

Ports:
- i_clk  input  1  source-domain clock.
- i_rst  input  1  asynchronous, active-high reset.
- i_valid  input  1  request to send i_data.
- i_data  input  DATA_WIDTH  word to send. Sampled only when i_valid && o_ready.
- o_ready  output  1  transmitter can accept a new word.
- o_xfer_data  output  DATA_WIDTH  registered word to the destination domain. Stable while o_xfer_req=1 and until ack is seen low.
- o_xfer_req  output  1  registered request to the destination domain. Driven straight from a flop, never from combinational logic.
- i_xfer_ack  input  1  asynchronous acknowledge from the destination domain.
- o_done  output  1  one-cycle pulse when a transfer completes normally.
- o_timeout  output  1  one-cycle pulse when a wait state times out.
- o_xfer_count  output  CNT_WIDTH  count of completed transfers. Wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, o_xfer_req=0, o_xfer_data=0.
  - o_done=0, o_timeout=0, o_xfer_count=0, timeout counter=0.
  - Ack synchronizer flops=0, so o_ready=1 after reset.
- ack_s is the output of the NUM_STAGES synchronizer. The FSM uses only ack_s, never raw i_xfer_ack.
- o_ready = (state==IDLE) && !ack_s.
- States:
  - IDLE: on i_valid && o_ready, latch i_data into o_xfer_data, set o_xfer_req=1, go to REQ. Cycle N accept gives o_xfer_req=1 at N+1.
  - REQ: wait for ack_s=1. Then clear o_xfer_req and go to REL. Data is not changed.
  - REL: wait for ack_s=0. Then go to IDLE, pulse o_done, increment o_xfer_count, all in the same cycle.
- Round trip is at least 2*NUM_STAGES+3 i_clk cycles plus destination latency.
- Back-to-back: o_ready returns to 1 on the o_done cycle, and a new i_valid is accepted in that cycle.
- Timeout counter:
  - Clears on every state change. Counts only in REQ and REL when TIMEOUT_CYCLES>0.
  - REQ timeout: pulse o_timeout, clear o_xfer_req, go to REL.
  - REL timeout: pulse o_timeout, go to IDLE.
  - A timed-out transfer never pulses o_done and does not increment o_xfer_count.
- Simultaneous events: if ack_s changes in the same cycle the counter reaches TIMEOUT_CYCLES, the ack wins. The transfer proceeds normally and o_timeout is not pulsed.
- ack_s=1 while IDLE (stale or stuck destination): o_ready=0 and no new request is issued until ack_s drops.
- i_valid while not ready is ignored. No queuing. The caller must hold i_valid.
- i_data changes outside the accept cycle have no effect on o_xfer_data.
- Reset mid-transfer: o_xfer_req drops asynchronously and the FSM returns to IDLE. The destination must tolerate an aborted req.
- o_xfer_count wraps from 2^CNT_WIDTH-1 to 0 without any flag.

Decomposition:
- Package com_cdc_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, REL} cdc_hs_state_t.
  - Minimum-stages constant (2), shared with the receiver-side block.
- Sub-module: instantiate com_cdc_synch (NUM_STAGES) for the i_xfer_ack path. This is the only clock-crossing element.
- The handshake FSM, timeout counter and transfer counter stay in com_cdc_hs_tx.

Test Plan:
- Single transfer, NUM_STAGES=2:
  - Stimulus: i_data=16'hA5C3, i_valid pulse at cycle 0. Responder raises ack 3 cycles after req and drops it 3 cycles after req falls.
  - Required: o_xfer_req=1 at cycle 1. o_xfer_data=16'hA5C3 held until o_done. Exactly one o_done pulse. o_xfer_count=1.
- Back-to-back:
  - Stimulus: 4 words 16'h0001..16'h0004 with i_valid held high.
  - Required: each word appears on o_xfer_data in order. A new req starts the cycle after each o_done. o_xfer_count=4, no o_timeout.
- REQ timeout:
  - Stimulus: TIMEOUT_CYCLES=8, responder never acks.
  - Required: o_xfer_req drops after 8 REQ cycles. One o_timeout pulse. Back to IDLE 8 cycles later with a second o_timeout pulse. o_done=0, o_xfer_count unchanged.
- Stuck ack:
  - Stimulus: i_xfer_ack=1 held from reset release.
  - Required: o_ready=0 after NUM_STAGES cycles. i_valid is ignored. o_ready=1 within NUM_STAGES+1 cycles of ack falling.
- Reset mid-transfer:
  - Stimulus: assert i_rst asynchronously while in REQ.
  - Required: o_xfer_req=0 and o_xfer_data=0 immediately. o_xfer_count=0. o_ready=1 after release.
- Counter wrap:
  - Stimulus: CNT_WIDTH=2, run 5 transfers.
  - Required: o_xfer_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/com_cdc_pkg.sv
// -----------------------------------------------------------------------------
// com_cdc_pkg
// Shared definitions for the req/ack clock-domain-crossing handshake blocks.
//   cdc_hs_state_t  : handshake FSM states (IDLE, REQ, REL)
//   CDC_MIN_STAGES  : smallest legal synchronizer depth, shared with the
//                     receiver-side block
//   cdc_ctr_width() : bit width needed to count 0 .. n-1 (at least 1)
// -----------------------------------------------------------------------------
package com_cdc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } cdc_hs_state_t;

    localparam int CDC_MIN_STAGES = 2;

    function automatic int cdc_ctr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/com_cdc_synch.sv
// -----------------------------------------------------------------------------
// com_cdc_synch
// Multi-flop synchronizer for a single asynchronous level signal.
// Ports:
//   i_clk   : destination clock
//   i_rst   : asynchronous, active-high reset (all stages cleared to 0)
//   i_async : asynchronous input level
//   o_sync  : synchronized level, NUM_STAGES i_clk edges of latency
// A NUM_STAGES value below CDC_MIN_STAGES is raised to CDC_MIN_STAGES so the
// chain never degenerates into a single metastable flop.
// -----------------------------------------------------------------------------
module com_cdc_synch
    import com_cdc_pkg::*;
#(
    parameter int NUM_STAGES = CDC_MIN_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync
);

    localparam int STAGES = (NUM_STAGES < CDC_MIN_STAGES) ? CDC_MIN_STAGES : NUM_STAGES;

    logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] sync_next;

    // Each stage samples its predecessor; stage 0 samples the raw input.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = i_async;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign o_sync = sync_reg[STAGES-1];

endmodule

// File: rtl/com_cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// com_cdc_hs_tx
// Source-side end of a 4-phase req/ack handshake carrying a DATA_WIDTH word
// out of the i_clk domain.
// Ports:
//   i_clk, i_rst  : source clock, asynchronous active-high reset
//   i_valid       : request to send i_data (sampled with o_ready)
//   i_data        : word to send
//   o_ready       : a new word can be accepted this cycle
//   o_xfer_data   : registered word towards the destination domain
//   o_xfer_req    : registered request towards the destination domain
//   i_xfer_ack    : asynchronous acknowledge from the destination domain
//   o_done        : one-cycle pulse on normal completion
//   o_timeout     : one-cycle pulse when a wait state runs out of time
//   o_xfer_count  : completed-transfer count, wraps silently
// -----------------------------------------------------------------------------
module com_cdc_hs_tx
    import com_cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int NUM_STAGES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_xfer_data,
    output logic                  o_xfer_req,
    input  logic                  i_xfer_ack,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [CNT_WIDTH-1:0]  o_xfer_count
);

    localparam bit TMO_EN = (TIMEOUT_CYCLES > 0);
    localparam int TMO_W  = cdc_ctr_width(TIMEOUT_CYCLES);
    // Last count value of a wait window: the edge that sees it ends the
    // TIMEOUT_CYCLES-th cycle spent in the state.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    cdc_hs_state_t         state_reg,   state_next;
    logic                  req_reg,     req_next;
    logic [DATA_WIDTH-1:0] data_reg,    data_next;
    logic                  done_reg,    done_next;
    logic                  tmo_reg,     tmo_next;
    logic [CNT_WIDTH-1:0]  count_reg,   count_next;
    logic [TMO_W-1:0]      tmo_cnt_reg, tmo_cnt_next;
    // Set when REQ gave up: the following REL is then a drain window that
    // only ends on timeout, giving a late ack time to rise and fall again.
    logic                  abort_reg,   abort_next;

    logic ack_s;
    logic ready;
    logic tmo_hit;

    com_cdc_synch #(
        .NUM_STAGES (NUM_STAGES)
    ) u_ack_synch (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_async (i_xfer_ack),
        .o_sync  (ack_s)
    );

    // A still-high ack in IDLE belongs to an older transfer; wait for it.
    assign ready   = (state_reg == IDLE) && !ack_s;
    assign tmo_hit = TMO_EN && (tmo_cnt_reg == TMO_LAST);

    always_comb begin
        state_next   = state_reg;
        req_next     = req_reg;
        data_next    = data_reg;
        count_next   = count_reg;
        abort_next   = abort_reg;
        tmo_cnt_next = tmo_cnt_reg;
        done_next    = 1'b0;
        tmo_next     = 1'b0;

        case (state_reg)
            IDLE: begin
                tmo_cnt_next = '0;
                if (i_valid && ready) begin
                    data_next  = i_data;
                    req_next   = 1'b1;
                    abort_next = 1'b0;
                    state_next = REQ;
                end
            end

            REQ: begin
                // Ack is tested first so it wins over a coincident timeout.
                if (ack_s) begin
                    req_next     = 1'b0;
                    tmo_cnt_next = '0;
                    state_next   = REL;
                end else if (tmo_hit) begin
                    tmo_next     = 1'b1;
                    req_next     = 1'b0;
                    abort_next   = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = REL;
                end else if (TMO_EN) begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end

            REL: begin
                if (!ack_s && !abort_reg) begin
                    done_next    = 1'b1;
                    count_next   = count_reg + 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = IDLE;
                end else if (tmo_hit) begin
                    tmo_next     = 1'b1;
                    tmo_cnt_next = '0;
                    state_next   = IDLE;
                end else if (TMO_EN) begin
                    tmo_cnt_next = tmo_cnt_reg + 1'b1;
                end
            end

            default: begin
                req_next     = 1'b0;
                tmo_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            req_reg     <= 1'b0;
            data_reg    <= '0;
            done_reg    <= 1'b0;
            tmo_reg     <= 1'b0;
            count_reg   <= '0;
            tmo_cnt_reg <= '0;
            abort_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            req_reg     <= req_next;
            data_reg    <= data_next;
            done_reg    <= done_next;
            tmo_reg     <= tmo_next;
            count_reg   <= count_next;
            tmo_cnt_reg <= tmo_cnt_next;
            abort_reg   <= abort_next;
        end
    end

    assign o_ready      = ready;
    assign o_xfer_req   = req_reg;
    assign o_xfer_data  = data_reg;
    assign o_done       = done_reg;
    assign o_timeout    = tmo_reg;
    assign o_xfer_count = count_reg;

endmodule

// File: tb/tb_com_cdc_hs_tx.sv
// -----------------------------------------------------------------------------
// tb_com_cdc_hs_tx
// Two transmitters share one stimulus: dut_a (16-bit counter) and dut_w
// (2-bit counter, for wrap-around). A transaction-level model predicts every
// output; directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_com_cdc_hs_tx;

    localparam int DW  = 16;
    localparam int NS  = 2;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          valid = 1'b0;
    logic [DW-1:0] data = '0;
    logic          ack = 1'b0;

    logic          a_ready, a_req, a_done, a_tmo;
    logic [DW-1:0] a_xdata;
    logic [15:0]   a_count;
    logic          w_ready, w_req, w_done, w_tmo;
    logic [DW-1:0] w_xdata;
    logic [1:0]    w_count;

    always #5 clk = ~clk;

    com_cdc_hs_tx #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(16)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .o_ready(a_ready),
        .o_xfer_data(a_xdata), .o_xfer_req(a_req), .i_xfer_ack(ack),
        .o_done(a_done), .o_timeout(a_tmo), .o_xfer_count(a_count));

    com_cdc_hs_tx #(.DATA_WIDTH(DW), .NUM_STAGES(NS), .TIMEOUT_CYCLES(TMO), .CNT_WIDTH(2)) dut_w (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data), .o_ready(w_ready),
        .o_xfer_data(w_xdata), .o_xfer_req(w_req), .i_xfer_ack(ack),
        .o_done(w_done), .o_timeout(w_tmo), .o_xfer_count(w_count));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // phase 0: idle, 1: request out waiting for ack, 2: waiting for release.
    int            m_phase = 0;
    int            m_cycles = 0;
    bit            m_abort = 0;
    bit            m_req = 0;
    logic [DW-1:0] m_data = '0;
    bit            m_done = 0;
    bit            m_tmo = 0;
    int unsigned   m_count = 0;
    bit            ack_seen [NS];   // ack_seen[k]: ack as sampled k+1 edges ago
    bit            m_acks;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_cycles = 0; m_abort = 0; m_req = 0; m_data = '0;
            m_done = 0; m_tmo = 0; m_count = 0;
            for (int k = 0; k < NS; k++) ack_seen[k] = 0;
        end else begin
            m_acks = ack_seen[NS-1];
            m_done = 0;
            m_tmo  = 0;
            case (m_phase)
                0: if (valid && !m_acks) begin
                    m_data = data; m_req = 1; m_phase = 1; m_cycles = 0; m_abort = 0;
                end
                1: if (m_acks) begin
                    m_req = 0; m_phase = 2; m_cycles = 0;
                end else begin
                    m_cycles++;
                    if (m_cycles == TMO) begin
                        m_tmo = 1; m_req = 0; m_abort = 1; m_phase = 2; m_cycles = 0;
                    end
                end
                default: if (!m_acks && !m_abort) begin
                    m_phase = 0; m_done = 1; m_count++;
                end else begin
                    m_cycles++;
                    if (m_cycles == TMO) begin
                        m_tmo = 1; m_phase = 0; m_cycles = 0;
                    end
                end
            endcase
            for (int k = NS-1; k > 0; k--) ack_seen[k] = ack_seen[k-1];
            ack_seen[0] = ack;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit chk_en = 0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_req",    {63'd0, a_req},   {63'd0, m_req});
            check("m_data",   {48'd0, a_xdata}, {48'd0, m_data});
            check("m_ready",  {63'd0, a_ready}, {63'd0, (m_phase == 0) && !ack_seen[NS-1]});
            check("m_done",   {63'd0, a_done},  {63'd0, m_done});
            check("m_tmo",    {63'd0, a_tmo},   {63'd0, m_tmo});
            check("m_count",  {48'd0, a_count}, {48'd0, m_count[15:0]});
            check("m_wreq",   {63'd0, w_req},   {63'd0, m_req});
            check("m_wcount", {62'd0, w_count}, {62'd0, m_count[1:0]});
        end
    end

    // ---------------- destination responder ----------------
    // mode 0: follow req after 3 cycles; 1: ack held low; 2: ack held high.
    int resp_mode = 0;
    int resp_cnt  = 0;
    always @(posedge clk) begin
        #2;
        case (resp_mode)
            1: begin ack = 1'b0; resp_cnt = 0; end
            2: begin ack = 1'b1; resp_cnt = 0; end
            default: begin
                if (a_req != ack) begin
                    resp_cnt++;
                    if (resp_cnt >= 3) begin ack = a_req; resp_cnt = 0; end
                end else begin
                    resp_cnt = 0;
                end
            end
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic run_xfer(input logic [DW-1:0] w);
        bit got;
        got = 0;
        valid = 1'b1;
        data  = w;
        tick();
        valid = 1'b0;
        for (int c = 0; c < 80 && !got; c++) begin
            tick();
            if (a_done) got = 1;
        end
        check("xfer_done_in_budget", {63'd0, got}, 64'd1);
    endtask

    int wrap_exp [5] = '{1, 2, 3, 0, 1};

    initial begin
        int dones, tmos, k, cyc, gap;
        bit got, rdy_prev, pend_req;

        #1 rst = 1'b1;
        chk_en = 1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_req",   {63'd0, a_req},   64'd0);
        check("rst_data",  {48'd0, a_xdata}, 64'd0);
        check("rst_ready", {63'd0, a_ready}, 64'd1);
        check("rst_count", {48'd0, a_count}, 64'd0);

        // single transfer
        valid = 1'b1;
        data  = 16'hA5C3;
        tick();
        valid = 1'b0;
        data  = 16'hFFFF;
        check("single_req_cycle1", {63'd0, a_req}, 64'd1);
        check("single_data", {48'd0, a_xdata}, 64'hA5C3);
        got = 0; dones = 0;
        for (int c = 0; c < 60 && !got; c++) begin
            tick();
            check("single_data_hold", {48'd0, a_xdata}, 64'hA5C3);
            if (a_done) begin got = 1; dones++; end
        end
        check("single_done_seen", {63'd0, got}, 64'd1);
        repeat (6) begin
            tick();
            if (a_done) dones++;
        end
        check("single_done_once", dones, 64'd1);
        check("single_count", {48'd0, a_count}, 64'd1);

        // back-to-back, i_valid held
        do_reset();
        k = 0; dones = 0; tmos = 0; pend_req = 0;
        valid = 1'b1;
        data  = 16'h0001;
        rdy_prev = a_ready;
        for (int c = 0; c < 300 && dones < 4; c++) begin
            tick();
            if (rdy_prev && valid) begin
                check("b2b_word", {48'd0, a_xdata}, k + 1);
                k++;
                if (k == 4) valid = 1'b0;
                else        data  = 16'(k + 1);
            end
            if (pend_req) begin
                check("b2b_req_after_done", {63'd0, a_req}, 64'd1);
                pend_req = 0;
            end
            if (a_done) begin
                dones++;
                if (k < 4) pend_req = 1;
            end
            if (a_tmo) tmos++;
            rdy_prev = a_ready;
        end
        check("b2b_dones", dones, 64'd4);
        check("b2b_count", {48'd0, a_count}, 64'd4);
        check("b2b_no_timeout", tmos, 64'd0);

        // REQ timeout with a silent destination
        do_reset();
        resp_mode = 1;
        valid = 1'b1;
        data  = 16'h5A5A;
        tick();
        valid = 1'b0;
        cyc = 1; dones = 0;
        for (int c = 0; c < 50 && a_req; c++) begin
            tick();
            if (a_done) dones++;
            if (a_req) cyc++;
        end
        check("tmo_req_cycles", cyc, 64'd8);
        check("tmo_first_pulse", {63'd0, a_tmo}, 64'd1);
        gap = 0; got = 0;
        for (int c = 0; c < 30 && !got; c++) begin
            tick();
            gap++;
            if (a_done) dones++;
            if (a_tmo) got = 1;
        end
        check("tmo_second_seen", {63'd0, got}, 64'd1);
        check("tmo_rel_gap", gap, 64'd8);
        check("tmo_no_done", dones, 64'd0);
        check("tmo_count", {48'd0, a_count}, 64'd0);
        check("tmo_ready", {63'd0, a_ready}, 64'd1);

        // stuck ack held from reset release
        rst = 1'b1;
        resp_mode = 2;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("stuck_ready_early", {63'd0, a_ready}, 64'd1);
        tick();
        check("stuck_ready_low", {63'd0, a_ready}, 64'd0);
        valid = 1'b1;
        data  = 16'h1234;
        repeat (5) begin
            tick();
            check("stuck_no_req", {63'd0, a_req}, 64'd0);
        end
        valid = 1'b0;
        // ack falls at the next responder update, one cycle after this point
        resp_mode = 1;
        got = 0; cyc = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            cyc++;
            if (a_ready) got = 1;
        end
        check("stuck_ready_back", {63'd0, got}, 64'd1);
        check("stuck_ready_latency_ok", {63'd0, cyc <= NS + 2}, 64'd1);
        resp_mode = 0;

        // reset in the middle of a transfer
        do_reset();
        run_xfer(16'h0F0F);
        valid = 1'b1;
        data  = 16'hBEEF;
        tick();
        valid = 1'b0;
        tick();
        check("mid_req_before", {63'd0, a_req}, 64'd1);
        #1 rst = 1'b1;
        #1;
        check("mid_req_cleared",   {63'd0, a_req},   64'd0);
        check("mid_data_cleared",  {48'd0, a_xdata}, 64'd0);
        check("mid_count_cleared", {48'd0, a_count}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        check("mid_ready_after", {63'd0, a_ready}, 64'd1);

        // counter wrap on the 2-bit instance
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_xfer(16'(16'h0010 + i));
            check("wrap_count", {62'd0, w_count}, wrap_exp[i]);
        end

        repeat (4) tick();
        chk_en = 0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule
